cascade_carry_counter: RTL and testbench
========================================

// Module: cascade_carry_counter
// PURPOSE
//   Downstream stage of the 2-bit binary counter: consumes its registered carry_out
//   pulse and counts it modulo MODULUS, forming the next digit of a cascaded counter.
//   Adds run/hold/clear control, a registered wrap pulse for further cascading and a
//   sticky overflow flag. Single clock domain. Synchronous, active-high reset.
// PARAMETERS
//   WIDTH    4   width of value; 2^WIDTH >= MODULUS required
//   MODULUS  10  count modulus; legal range 2..2^WIDTH; value counts 0..MODULUS-1
// PORTS
//   clk        in   1      rising-edge clock; shared with the upstream counter
//   reset      in   1      synchronous, active-high reset
//   carry_in   in   1      upstream carry_out; one-cycle pulse = one count event
//   start      in   1      command: enter/resume RUN
//   stop       in   1      command: freeze count (enter HOLD)
//   clear      in   1      command: zero value and overflow, return to IDLE
//   value      out  WIDTH  current count, registered
//   carry_out  out  1      registered one-cycle pulse on wrap MODULUS-1 -> 0
//   running    out  1      1 while state == RUN, registered
//   overflow   out  1      sticky; set on first wrap (or saturation attempt), cleared by clear
// BEHAVIOUR
//   - Reset (sampled on clk): value=0, carry_out=0, running=0, overflow=0, state=IDLE.
//     Reset overrides every other input in the same cycle.
//   - Command priority: reset > clear > stop > start.
//   - States: IDLE --start--> RUN; RUN --stop--> HOLD; HOLD --start--> RUN;
//     any --clear--> IDLE. All other combinations stay in the current state.
//   - Counting uses the current state only: a carry_in in the cycle that start is
//     asserted in IDLE is NOT counted. A carry_in in the cycle that stop is asserted
//     in RUN IS counted.
//   - In RUN with carry_in=1: if value < MODULUS-1, value <= value+1. If
//     value == MODULUS-1, value <= 0, carry_out <= 1 and overflow <= 1.
//     All results appear one cycle after the sampling edge.
//   - carry_out is 1 for exactly one cycle, coincident with value==0 after a wrap.
//     carry_out is 0 in every other cycle, including after clear and after reset.
//   - IDLE and HOLD ignore carry_in; value is frozen. In IDLE, value is 0 after clear/reset.
//   - clear: value <= 0, overflow <= 0, carry_out <= 0, state <= IDLE. This holds
//     even when it coincides with a wrapping carry_in.
//   - running mirrors the next state: it goes to 1 on the edge after start and to 0
//     on the edge after stop or clear.
//   - Back-to-back carry_in pulses (every cycle) count one per cycle, with no lost events.
//   - value never leaves 0..MODULUS-1. No X on any output after reset.
// CONFIGURATION
//   CASCADE_SATURATE_EN defined: in RUN, carry_in at value==MODULUS-1 holds
//     value at MODULUS-1, sets overflow and leaves carry_out at 0 (no wrap).
//     carry_out is therefore never asserted.
//   CASCADE_SATURATE_EN undefined (default): wrap behaviour as above.
// TESTING
//   1. reset=1 for 2 cycles with carry_in=1 and start=1 -> value=0, carry_out=0,
//      running=0, overflow=0.
//   2. MODULUS=10: start, then 10 carry_in pulses spaced 4 cycles apart -> value steps
//      1..9, then 0; carry_out=1 for exactly one cycle with value=0; overflow=1.
//   3. start and carry_in in the same cycle from IDLE -> value stays 0; stop and
//      carry_in in the same cycle from RUN at value=3 -> value=4, then frozen in HOLD
//      while 5 more pulses are ignored.
//   4. value=9 in RUN, clear and carry_in in the same cycle -> value=0, carry_out=0,
//      overflow=0, state IDLE.
//   5. carry_in=1 every cycle for 25 cycles in RUN -> value=5, carry_out pulsed twice,
//      10 cycles apart.
//   6. CASCADE_SATURATE_EN defined: 12 pulses in RUN -> value held at 9,
//      overflow=1, carry_out never 1.

Source files
------------

// File: rtl/cascade_carry_counter.sv
// Modulo-MODULUS digit stage fed by an upstream carry pulse, with run/hold/clear control.
// Define CASCADE_SATURATE_EN to hold at MODULUS-1 instead of wrapping (carry_out then never pulses).
module cascade_carry_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carry_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             carry_out,
    output logic             running,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             running_q, running_d;
    logic             overflow_q, overflow_d;
    logic             count_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            carry_q    <= 1'b0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            carry_q    <= carry_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
        end
    end

    // Command decode; stop outranks start, so both together never enter RUN.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_HOLD;
            end
        end else if (start) begin
            if (state_q == ST_IDLE || state_q == ST_HOLD) begin
                state_d = ST_RUN;
            end
        end
    end

    assign count_en = (state_q == ST_RUN) && carry_in;

    always_comb begin
        value_d    = value_q;
        carry_d    = 1'b0;
        overflow_d = overflow_q;
        running_d  = (state_d == ST_RUN);
        if (clear) begin
            value_d    = '0;
            overflow_d = 1'b0;
        end else if (count_en) begin
            if (value_q == MAX_VAL) begin
`ifdef CASCADE_SATURATE_EN
                value_d    = MAX_VAL;
`else
                value_d    = '0;
                carry_d    = 1'b1;
`endif
                overflow_d = 1'b1;
            end else begin
                value_d = value_q + 1'b1;
            end
        end
    end

    assign value     = value_q;
    assign carry_out = carry_q;
    assign running   = running_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cascade_carry_counter.sv
// Randomized and scenario bench for cascade_carry_counter against a behavioural model.
module tb_cascade_carry_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset, carry_in, start, stop, clear;
    logic [W-1:0] value;
    logic         carry_out, running, overflow;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 = idle, 1 = run, 2 = hold
    int m_mode = 0;
    int m_val  = 0;
    bit m_co   = 0;
    bit m_ov   = 0;

    always #5 clk = ~clk;

    cascade_carry_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .carry_in  (carry_in),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .value     (value),
        .carry_out (carry_out),
        .running   (running),
        .overflow  (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit s, input bit p, input bit cl);
        if (r) begin
            m_mode = 0; m_val = 0; m_co = 0; m_ov = 0;
            return;
        end
        m_co = 0;
        if (cl) begin
            m_val = 0; m_ov = 0; m_mode = 0;
            return;
        end
        if (m_mode == 1 && c) begin
            if (m_val + 1 < M) begin
                m_val = m_val + 1;
            end else begin
`ifdef CASCADE_SATURATE_EN
                m_val = M - 1;
`else
                m_val = 0;
                m_co  = 1;
`endif
                m_ov = 1;
            end
        end
        if (p) begin
            if (m_mode == 1) m_mode = 2;
        end else if (s) begin
            if (m_mode != 1) m_mode = 1;
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input bit r, input bit c, input bit s, input bit p, input bit cl);
        reset = r; carry_in = c; start = s; stop = p; clear = cl;
        @(posedge clk);
        model_update(r, c, s, p, cl);
        #1;
        check_eq("value",     32'(value),     32'(m_val));
        check_eq("carry_out", 32'(carry_out), 32'(m_co));
        check_eq("running",   32'(running),   32'(m_mode == 1));
        check_eq("overflow",  32'(overflow),  32'(m_ov));
    endtask

    int pulses;
    int first_at;
    int gap;

    initial begin
        reset = 1'b0; carry_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;

        // Reset dominates simultaneous carry and start.
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check_eq("rst_value", 32'(value), 0);
        check_eq("rst_carry", 32'(carry_out), 0);
        check_eq("rst_running", 32'(running), 0);
        check_eq("rst_overflow", 32'(overflow), 0);

        // Ten spaced pulses from zero.
        step(0, 0, 1, 0, 0);
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 0, 0, 0);
`ifdef CASCADE_SATURATE_EN
            check_eq("spaced_value", 32'(value), (i < M) ? i : M - 1);
`else
            check_eq("spaced_value", 32'(value), i % M);
`endif
            if (carry_out) pulses++;
            for (int k = 0; k < 3; k++) begin
                step(0, 0, 0, 0, 0);
                if (carry_out) pulses++;
            end
        end
`ifdef CASCADE_SATURATE_EN
        check_eq("spaced_pulses", 32'(pulses), 0);
`else
        check_eq("spaced_pulses", 32'(pulses), 1);
`endif
        check_eq("spaced_overflow", 32'(overflow), 1);

        // start+carry from IDLE is not counted; stop+carry from RUN is.
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        check_eq("start_carry_value", 32'(value), 0);
        check_eq("start_running", 32'(running), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        check_eq("pre_stop_value", 32'(value), 3);
        step(0, 1, 0, 1, 0);
        check_eq("stop_carry_value", 32'(value), 4);
        check_eq("stop_running", 32'(running), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        check_eq("hold_frozen", 32'(value), 4);

        // clear coinciding with a wrapping carry.
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
        check_eq("at_max", 32'(value), M - 1);
        step(0, 1, 0, 0, 1);
        check_eq("clr_value", 32'(value), 0);
        check_eq("clr_carry", 32'(carry_out), 0);
        check_eq("clr_overflow", 32'(overflow), 0);
        check_eq("clr_running", 32'(running), 0);

        // Back-to-back carries for 25 cycles.
        step(0, 0, 1, 0, 0);
        pulses = 0; first_at = -1; gap = -1;
        for (int i = 0; i < 25; i++) begin
            step(0, 1, 0, 0, 0);
            if (carry_out) begin
                if (pulses == 0) first_at = i;
                else gap = i - first_at;
                pulses++;
            end
        end
`ifdef CASCADE_SATURATE_EN
        check_eq("b2b_value", 32'(value), M - 1);
        check_eq("b2b_pulses", 32'(pulses), 0);
`else
        check_eq("b2b_value", 32'(value), 5);
        check_eq("b2b_pulses", 32'(pulses), 2);
        check_eq("b2b_gap", 32'(gap), 10);
`endif
        check_eq("b2b_overflow", 32'(overflow), 1);

        // Randomized commands and carries against the model.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 199) < 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
